// File: rtl/wt_inval_queue.sv
// ============================================================================
// Module   : wt_inval_queue
// Purpose  : Line-aligned, coalescing invalidation FIFO feeding the WT cache.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module wt_inval_queue #(
  parameter int Depth          = 4,
  parameter int AddrWidth      = 64,
  parameter int LineOffsetBits = 4
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       snoop_valid_i,
  input  logic [AddrWidth-1:0]       snoop_addr_i,
  output logic                       snoop_ready_o,
  output logic                       inval_valid_o,
  output logic [AddrWidth-1:0]       inval_addr_o,
  input  logic                       inval_ready_i,
  output logic [$clog2(Depth):0]     count_o,
  output logic [15:0]                coalesced_cnt_o,
  output logic                       empty_o
);

  localparam int PW = $clog2(Depth);
  localparam int CW = PW + 1;

  logic [AddrWidth-1:0] r_mem [Depth];
  logic [Depth-1:0]     r_vld;
  logic [PW-1:0]        r_rd_ptr;
  logic [PW-1:0]        r_wr_ptr;
  logic [CW-1:0]        r_cnt;
  logic [15:0]          r_coal;

  logic [AddrWidth-1:0] w_line;
  logic [Depth-1:0]     w_hit;
  logic                 w_match;
  logic                 w_pop;
  logic                 w_acc;
  logic                 w_push;
  logic                 w_coal;
  logic                 w_unused_lsbs;

  assign w_line        = {snoop_addr_i[AddrWidth-1:LineOffsetBits], {LineOffsetBits{1'b0}}};
  assign w_unused_lsbs = ^snoop_addr_i[LineOffsetBits-1:0];
  assign w_pop         = (r_cnt != '0) && inval_ready_i;

  // A head that leaves this cycle must not absorb a new request for the same line.
  for (genvar i = 0; i < Depth; i++) begin : g_match
    assign w_hit[i] = r_vld[i] && (r_mem[i] == w_line) && !(w_pop && (r_rd_ptr == PW'(i)));
  end

  assign w_match       = |w_hit;
  assign snoop_ready_o = w_match || (r_cnt < CW'(Depth));
  assign w_acc         = snoop_valid_i && snoop_ready_o;
  assign w_push        = w_acc && !w_match;
  assign w_coal        = w_acc && w_match;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < Depth; i++) begin
        r_mem[i] <= '0;
      end
      r_vld    <= '0;
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_cnt    <= '0;
      r_coal   <= '0;
    end else begin
      if (w_pop) begin
        r_vld[r_rd_ptr] <= 1'b0;
        r_rd_ptr        <= r_rd_ptr + PW'(1);
      end
      if (w_push) begin
        r_mem[r_wr_ptr] <= w_line;
        r_vld[r_wr_ptr] <= 1'b1;
        r_wr_ptr        <= r_wr_ptr + PW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + CW'(1);
        2'b01:   r_cnt <= r_cnt - CW'(1);
        default: r_cnt <= r_cnt;
      endcase
      if (w_coal && (r_coal != 16'hFFFF)) begin
        r_coal <= r_coal + 16'd1;
      end
    end
  end

  assign inval_valid_o   = (r_cnt != '0);
  assign inval_addr_o    = r_mem[r_rd_ptr];
  assign count_o         = r_cnt;
  assign coalesced_cnt_o = r_coal;
  assign empty_o         = (r_cnt == '0);

endmodule

`default_nettype wire

// File: tb/tb_wt_inval_queue.sv
// ============================================================================
// Module   : tb_wt_inval_queue
// Purpose  : Directed plus randomized checks of wt_inval_queue against a queue model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_wt_inval_queue;

  localparam int c_depth = 4;

  logic        clk;
  logic        rst;
  logic        snoop_valid;
  logic [63:0] snoop_addr;
  logic        snoop_ready;
  logic        inval_valid;
  logic [63:0] inval_addr;
  logic        inval_ready;
  logic [2:0]  count;
  logic [15:0] coal_cnt;
  logic        empty;

  wt_inval_queue #(.Depth(c_depth), .AddrWidth(64), .LineOffsetBits(4)) u_dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .snoop_valid_i  (snoop_valid),
    .snoop_addr_i   (snoop_addr),
    .snoop_ready_o  (snoop_ready),
    .inval_valid_o  (inval_valid),
    .inval_addr_o   (inval_addr),
    .inval_ready_i  (inval_ready),
    .count_o        (count),
    .coalesced_cnt_o(coal_cnt),
    .empty_o        (empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: pending lines in emission order plus a saturating counter.
  logic [63:0] m_q [$];
  int          m_coal = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic chk_state();
    chk("valid", {63'd0, inval_valid}, {63'd0, m_q.size() != 0});
    chk("count", {61'd0, count}, 64'(m_q.size()));
    chk("empty", {63'd0, empty}, {63'd0, m_q.size() == 0});
    chk("coal",  {48'd0, coal_cnt}, 64'(m_coal));
    if (m_q.size() != 0) chk("head", inval_addr, m_q[0]);
  endtask

  // Entered just after a falling edge; returns just after the next falling edge.
  task automatic step(input logic v, input logic [63:0] a, input logic r, output logic rdy);
    logic [63:0] line;
    logic        pop;
    logic        match;
    logic        exp_rdy;
    snoop_valid = v;
    snoop_addr  = a;
    inval_ready = r;
    #1;
    line  = {a[63:4], 4'h0};
    pop   = (m_q.size() != 0) && r;
    match = 1'b0;
    for (int k = 0; k < m_q.size(); k++) begin
      if (!(pop && k == 0) && m_q[k] == line) match = 1'b1;
    end
    exp_rdy = match || (m_q.size() < c_depth);
    rdy = snoop_ready;
    chk("snoop_ready", {63'd0, snoop_ready}, {63'd0, exp_rdy});
    @(posedge clk);
    if (pop) void'(m_q.pop_front());
    if (v && exp_rdy) begin
      if (match) begin
        if (m_coal < 16'hFFFF) m_coal++;
      end else begin
        m_q.push_back(line);
      end
    end
    #1;
    chk_state();
    @(negedge clk);
  endtask

  task automatic drain();
    logic rdy;
    for (int k = 0; k < c_depth + 2 && m_q.size() != 0; k++) step(1'b0, 64'd0, 1'b1, rdy);
    chk("drained", 64'(m_q.size()), 64'd0);
  endtask

  logic        rdy;
  logic [63:0] exp_order [5];

  initial begin
    rst         = 1'b1;
    snoop_valid = 1'b0;
    snoop_addr  = '0;
    inval_ready = 1'b0;
    #1;
    chk("rst_valid", {63'd0, inval_valid}, 64'd0);
    chk("rst_addr",  inval_addr, 64'd0);
    chk("rst_count", {61'd0, count}, 64'd0);
    chk("rst_coal",  {48'd0, coal_cnt}, 64'd0);
    chk("rst_empty", {63'd0, empty}, 64'd1);
    snoop_valid = 1'b1;
    snoop_addr  = 64'hB00;
    #1;
    chk("rst_ready", {63'd0, snoop_ready}, 64'd1);
    @(posedge clk);
    @(negedge clk);
    rst         = 1'b0;
    snoop_valid = 1'b0;
    #1;
    chk("rst_no_accept", {61'd0, count}, 64'd0);

    // Single request into an empty queue.
    step(1'b1, 64'h8000_1234, 1'b0, rdy);
    chk("single_addr", inval_addr, 64'h8000_1230);
    chk("single_cnt", {61'd0, count}, 64'd1);
    step(1'b0, 64'd0, 1'b1, rdy);
    chk("single_empty", {63'd0, empty}, 64'd1);

    // Coalescing within one line.
    step(1'b1, 64'h100, 1'b0, rdy);
    step(1'b1, 64'h108, 1'b0, rdy);
    step(1'b1, 64'h10F, 1'b0, rdy);
    chk("coal_cnt1", {61'd0, count}, 64'd1);
    chk("coal_val", {48'd0, coal_cnt}, 64'd2);
    chk("coal_head", inval_addr, 64'h100);
    drain();

    // Full queue and back-pressure.
    for (int k = 0; k < 4; k++) step(1'b1, 64'(k * 16), 1'b0, rdy);
    step(1'b1, 64'h040, 1'b0, rdy);
    chk("full_reject", {63'd0, rdy}, 64'd0);
    step(1'b1, 64'h020, 1'b0, rdy);
    chk("full_dup_rdy", {63'd0, rdy}, 64'd1);
    chk("full_dup_coal", {48'd0, coal_cnt}, 64'd3);
    step(1'b1, 64'h040, 1'b1, rdy);
    chk("full_pop_reject", {63'd0, rdy}, 64'd0);
    step(1'b1, 64'h040, 1'b0, rdy);
    chk("after_pop_accept", {63'd0, rdy}, 64'd1);
    exp_order = '{64'h010, 64'h020, 64'h030, 64'h040, 64'h040};
    for (int k = 0; k < 4; k++) begin
      chk("drain_order", inval_addr, exp_order[k]);
      step(1'b0, 64'd0, 1'b1, rdy);
    end
    chk("drain_empty", {63'd0, empty}, 64'd1);

    // Head-pop exclusion, then pointer wrap.
    step(1'b1, 64'h500, 1'b0, rdy);
    step(1'b1, 64'h500, 1'b1, rdy);
    chk("excl_cnt", {61'd0, count}, 64'd1);
    chk("excl_addr", inval_addr, 64'h500);
    chk("excl_coal", {48'd0, coal_cnt}, 64'd3);
    for (int k = 0; k < 10; k++) step(1'b1, 64'h600 + 64'(k * 16), 1'b1, rdy);
    chk("wrap_head", inval_addr, 64'h690);
    drain();

    // Asynchronous reset mid-stream.
    for (int k = 0; k < 3; k++) step(1'b1, 64'hA00 + 64'(k * 16), 1'b0, rdy);
    #2;
    rst = 1'b1;
    #1;
    m_q.delete();
    m_coal = 0;
    chk("arst_valid", {63'd0, inval_valid}, 64'd0);
    chk("arst_count", {61'd0, count}, 64'd0);
    chk("arst_coal",  {48'd0, coal_cnt}, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    step(1'b1, 64'h700, 1'b0, rdy);
    chk("post_rst_head", inval_addr, 64'h700);
    chk("post_rst_cnt", {61'd0, count}, 64'd1);
    drain();

    // Randomized traffic over a small line set so duplicates are frequent.
    for (int k = 0; k < 400; k++) begin
      step(1'($urandom_range(0, 1)), 64'($urandom_range(0, 7) * 16 + $urandom_range(0, 15)),
           1'($urandom_range(0, 2) == 0), rdy);
    end
    drain();

    // Counter saturation.
    step(1'b1, 64'h900, 1'b0, rdy);
    for (int k = 0; k < 70000; k++) step(1'b1, 64'h900, 1'b0, rdy);
    chk("sat_coal", {48'd0, coal_cnt}, 64'hFFFF);
    chk("sat_cnt", {61'd0, count}, 64'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/wt_inval_queue.md
# wt_inval_queue

Invalidation request queue that collects cache-line invalidation addresses from the external coherence/snoop source and feeds them one at a time to the write-through cache subsystem's `inval_addr`/`inval_valid`/`inval_ready` port. It aligns addresses to the D$ line and coalesces duplicate lines already pending. It absorbs bursts while the cache is busy with a bounded FIFO, and exposes occupancy and coalescing statistics for the performance counters.

## Interface

Parameters:
- `Depth`, 4: FIFO entries; power of two, ≥2.
- `AddrWidth`, 64: physical address width.
- `LineOffsetBits`, 4: low address bits cleared for line alignment (16-byte D$ line).

Ports:
- `clk_i`  in  1  clock; all state updates on the rising edge.
- `rst_i`  in  1  reset; asynchronous, active-high.
- `snoop_valid_i`  in  1  incoming invalidation request.
- `snoop_addr_i`  in  AddrWidth  byte address to invalidate.
- `snoop_ready_o`  out  1  request accepted this cycle when high together with `snoop_valid_i`.
- `inval_valid_o`  out  1  head entry valid toward the cache subsystem.
- `inval_addr_o`  out  AddrWidth  line-aligned head address; low `LineOffsetBits` bits are always 0.
- `inval_ready_i`  in  1  cache subsystem consumes the head.
- `count_o`  out  $clog2(Depth)+1  current occupancy.
- `coalesced_cnt_o`  out  16  saturating count of requests dropped as duplicates.
- `empty_o`  out  1  occupancy is 0.

## Operation

- **Storage:** circular FIFO with `Depth` line-address registers, a per-entry valid bit, read pointer `rd_ptr`, write pointer `wr_ptr`, and occupancy `cnt`.
- **Pointer width:** pointers are log2(Depth) bits and wrap naturally from Depth-1 to 0.
- **Alignment:** `line = {snoop_addr_i[AddrWidth-1:LineOffsetBits], LineOffsetBits'b0}`.
- **Match:** asserted when `line` equals any valid entry. The head entry is excluded from the match when it pops in the same cycle (`inval_valid_o && inval_ready_i`).
- **Accept:** `snoop_ready_o = match || (cnt < Depth)`. It is combinational from `snoop_addr_i` and the FIFO state, and does not depend on `snoop_valid_i`.
- **On accept with match:**
  - no entry is written;
  - `coalesced_cnt_o` increments and saturates at 0xFFFF.
- **On accept without match:**
  - `line` is written at `wr_ptr`;
  - `wr_ptr` increments and `cnt` increments.
- **Pop:** when `inval_valid_o && inval_ready_i`, the head is invalidated and `rd_ptr` increments.
- **Simultaneous push and pop:** `cnt` is unchanged.
- **Full queue:** when `cnt == Depth`, a non-matching request is not accepted in that cycle even if a pop occurs. There is no pass-through; the request is accepted the next cycle.
- **Outputs:**
  - `inval_valid_o = (cnt != 0)`;
  - `inval_addr_o` = entry at `rd_ptr`, driven directly from registers;
  - `count_o = cnt`;
  - `empty_o = (cnt == 0)`.
- **Ordering:** invalidations are emitted in first-accept order. Coalescing never reorders entries.
- **Output stability:** once `inval_valid_o` is high, `inval_valid_o` and `inval_addr_o` stay stable until `inval_ready_i` is sampled high (AXI-style valid/ready).

## Timing

- **Reset:** asynchronous assertion of `rst_i` immediately clears all valid bits, pointers, `cnt` and `coalesced_cnt_o`.
  - Outputs during and after reset: `inval_valid_o`=0, `inval_addr_o`=0, `count_o`=0, `coalesced_cnt_o`=0, `empty_o`=1.
  - `snoop_ready_o`=1 during reset, but no request is accepted while `rst_i` is high.
  - Entry data registers are cleared to 0.
- **Reset mid-operation:** pending entries are discarded without a handshake. `inval_valid_o` falls in the same cycle as `rst_i` rises.
- **Latency:**
  - A request accepted at edge N into an empty queue shows `inval_valid_o`=1 after edge N, i.e. a 1-cycle latency.
  - With `inval_ready_i` held high, throughput is 1 invalidation per cycle.
- **Combinational paths:**
  - `snoop_ready_o` depends combinationally on `snoop_addr_i` and on `inval_ready_i` (through the head exclusion rule).
  - No other input-to-output combinational path exists.

## Test plan

- **Single request, empty queue:** with the queue empty, push `snoop_addr_i`=0x8000_1234 and hold `inval_ready_i`=0.
  - Next cycle: `inval_valid_o`=1, `inval_addr_o`=0x8000_1230, `count_o`=1.
  - Assert `inval_ready_i` for one cycle: `empty_o`=1 the following cycle.
- **Coalescing:** push 0x100, 0x108 and 0x10F with `inval_ready_i`=0.
  - Exactly one entry 0x100 is queued, `count_o`=1, `coalesced_cnt_o`=2.
- **Full / back-pressure:** with Depth=4 and `inval_ready_i`=0, push 0x000, 0x010, 0x020, 0x030, then 0x040.
  - `snoop_ready_o`=0 for 0x040.
  - Pushing 0x020 while full is accepted, with `coalesced_cnt_o`+1.
  - Pulsing `inval_ready_i`: 0x040 is accepted the cycle after the pop.
  - The drain order is 0x000, 0x010, 0x020, 0x030, 0x040.
- **Head-pop exclusion and wrap:** with the queue holding only head 0x500 and `inval_ready_i`=1, push 0x500 in the same cycle.
  - The new 0x500 is enqueued, not coalesced: `count_o` stays 1 and `inval_addr_o`=0x500 the next cycle.
  - Repeat 10 push/pop pairs so the pointers wrap; addresses stay in FIFO order.
- **Reset mid-stream:** with 3 entries queued, assert `rst_i` asynchronously between clock edges.
  - `inval_valid_o`, `count_o` and `coalesced_cnt_o` go to 0 immediately.
  - After release, a new push of 0x700 appears alone at the head.
- **Saturation:** force 70000 duplicate requests of 0x900.
  - `coalesced_cnt_o` holds at 0xFFFF.
  - `count_o`=1 throughout.
